// File: rtl/pcileech_pcie_tlp_width_bridge_if.sv
// rtl/pcileech_pcie_tlp_width_bridge_if.sv - core AXI-stream and DW FIFO bundle for the TLP width bridge
interface pcileech_pcie_tlp_width_bridge_if #(
    parameter int DATA_W = 64
);
    localparam int KEEP_W = DATA_W / 8;

    // core RX stream (core -> bridge)
    logic [DATA_W-1:0] m_axis_rx_tdata;
    logic [KEEP_W-1:0] m_axis_rx_tkeep;
    logic              m_axis_rx_tlast;
    logic              m_axis_rx_tvalid;
    logic              m_axis_rx_tready;

    logic              cfg_command_bus_master_enable;

    // DW stream towards the FIFO: [31:0] DW, [32] last, [33] BME
    logic [33:0]       tlp_tx_data;
    logic              tlp_tx_valid;
    logic              tlp_tx_ready;

    // DW stream from the FIFO: [31:0] DW, [32] last, [33] ignored
    logic [33:0]       tlp_rx_data;
    logic              tlp_rx_valid;
    logic              tlp_rx_ready;

    // core TX stream (bridge -> core)
    logic [DATA_W-1:0] s_axis_tx_tdata;
    logic [KEEP_W-1:0] s_axis_tx_tkeep;
    logic              s_axis_tx_tlast;
    logic              s_axis_tx_tvalid;
    logic              s_axis_tx_tready;

    // bridge side
    modport slave (
        input  m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
        output m_axis_rx_tready,
        input  cfg_command_bus_master_enable,
        output tlp_tx_data, tlp_tx_valid,
        input  tlp_tx_ready,
        input  tlp_rx_data, tlp_rx_valid,
        output tlp_rx_ready,
        output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tvalid,
        input  s_axis_tx_tready
    );

    // core + FIFO side
    modport master (
        output m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
        input  m_axis_rx_tready,
        output cfg_command_bus_master_enable,
        input  tlp_tx_data, tlp_tx_valid,
        output tlp_tx_ready,
        output tlp_rx_data, tlp_rx_valid,
        input  tlp_rx_ready,
        input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tvalid,
        output s_axis_tx_tready
    );
endinterface

// File: rtl/pcileech_pcie_tlp_width_bridge.sv
// rtl/pcileech_pcie_tlp_width_bridge.sv - unpacks core RX beats into DWs and packs FIFO DWs into core TX beats
module pcileech_pcie_tlp_width_bridge #(
    parameter int DATA_W = 64
) (
    input  logic                                   user_clk,
    input  logic                                   user_reset,
    pcileech_pcie_tlp_width_bridge_if.slave        bus
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int NL     = DATA_W / 32;
    localparam int LW     = (NL > 1) ? $clog2(NL) : 1;
    localparam int CW     = $clog2(NL + 1);

    generate
        if (DATA_W != 32 && DATA_W != 64 && DATA_W != 128) begin : g_bad_width
            $error("pcileech_pcie_tlp_width_bridge: DATA_W must be 32, 64 or 128");
        end
    endgenerate

    // ---------------- RX unpack ----------------
    // rx_data_q shifts down one DW per emit so the presented DW is always [31:0];
    // rx_rem_q counts DWs still to emit, zero meaning the register is empty.
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [CW-1:0]     rx_rem_q, rx_rem_d;
    logic              rx_last_q, rx_last_d;
    logic              rx_bme_q, rx_bme_d;
    logic [CW-1:0]     rx_lanes;
    logic              rx_full, rx_final, rx_accept, rx_pop;

    assign rx_full  = (rx_rem_q != '0);
    assign rx_final = (rx_rem_q == CW'(1));
    assign rx_pop   = rx_full && bus.tlp_tx_ready;

    // a new beat may enter in the same cycle the final DW of the previous one leaves
    assign bus.m_axis_rx_tready = !user_reset && (!rx_full || (bus.tlp_tx_ready && rx_final));
    assign rx_accept            = bus.m_axis_rx_tvalid && bus.m_axis_rx_tready;

    assign bus.tlp_tx_valid = !user_reset && rx_full;
    assign bus.tlp_tx_data  = bus.tlp_tx_valid ? {rx_bme_q, rx_last_q && rx_final, rx_data_q[31:0]} : '0;

    // count full-DW keep groups; valid lanes are contiguous from lane 0
    always_comb begin
        rx_lanes = '0;
        for (int i = 0; i < NL; i++) begin
            if (bus.m_axis_rx_tkeep[i*4 +: 4] == 4'hF) rx_lanes = CW'(i + 1);
        end
    end

    // capture a beat or advance to the next DW
    always_comb begin
        rx_data_d = rx_data_q;
        rx_rem_d  = rx_rem_q;
        rx_last_d = rx_last_q;
        rx_bme_d  = rx_bme_q;
        if (rx_accept) begin
            rx_data_d = bus.m_axis_rx_tdata;
            rx_rem_d  = rx_lanes;
            rx_last_d = bus.m_axis_rx_tlast;
            rx_bme_d  = bus.cfg_command_bus_master_enable;
        end else if (rx_pop) begin
            rx_data_d = rx_data_q >> 32;
            rx_rem_d  = rx_rem_q - 1'b1;
        end
    end

    // unpack register state
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            rx_data_q <= '0;
            rx_rem_q  <= '0;
            rx_last_q <= 1'b0;
            rx_bme_q  <= 1'b0;
        end else begin
            rx_data_q <= rx_data_d;
            rx_rem_q  <= rx_rem_d;
            rx_last_q <= rx_last_d;
            rx_bme_q  <= rx_bme_d;
        end
    end

    // ---------------- TX pack ----------------
    // tx_acc_q gathers DWs of the beat being built; closed beats move to the tx_*_q output holding regs.
    logic [DATA_W-1:0] tx_acc_q, tx_acc_d;
    logic [LW-1:0]     tx_lane_q, tx_lane_d;
    logic              tx_pend_q, tx_pend_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [KEEP_W-1:0] tx_keep_q, tx_keep_d;
    logic              tx_last_q, tx_last_d;
    logic [DATA_W-1:0] tx_merged;
    logic [KEEP_W-1:0] tx_fill;
    logic              tx_accept, tx_close;
    logic              unused_rx_bit33;

    assign unused_rx_bit33 = bus.tlp_rx_data[33];

    assign bus.tlp_rx_ready = !user_reset && (!tx_pend_q || bus.s_axis_tx_tready);
    assign tx_accept        = bus.tlp_rx_valid && bus.tlp_rx_ready;
    assign tx_close         = tx_accept && (bus.tlp_rx_data[32] || (tx_lane_q == LW'(NL - 1)));

    assign bus.s_axis_tx_tvalid = !user_reset && tx_pend_q;
    assign bus.s_axis_tx_tdata  = user_reset ? '0 : tx_data_q;
    assign bus.s_axis_tx_tkeep  = user_reset ? '0 : tx_keep_q;
    assign bus.s_axis_tx_tlast  = !user_reset && tx_last_q;

    // insert the incoming DW at the current lane and form the keep mask of filled lanes
    always_comb begin
        tx_merged = tx_acc_q;
        tx_fill   = '0;
        for (int i = 0; i < NL; i++) begin
            if (LW'(i) == tx_lane_q) tx_merged[i*32 +: 32] = bus.tlp_rx_data[31:0];
            if (LW'(i) <= tx_lane_q) tx_fill[i*4 +: 4] = 4'hF;
        end
    end

    // accumulate DWs, close beats, retire the pending beat on core handshake
    always_comb begin
        tx_acc_d  = tx_acc_q;
        tx_lane_d = tx_lane_q;
        tx_pend_d = tx_pend_q;
        tx_data_d = tx_data_q;
        tx_keep_d = tx_keep_q;
        tx_last_d = tx_last_q;
        if (tx_pend_q && bus.s_axis_tx_tready) tx_pend_d = 1'b0;
        if (tx_close) begin
            tx_data_d = tx_merged;
            tx_keep_d = tx_fill;
            tx_last_d = bus.tlp_rx_data[32];
            tx_pend_d = 1'b1;
            tx_acc_d  = '0;
            tx_lane_d = '0;
        end else if (tx_accept) begin
            tx_acc_d  = tx_merged;
            tx_lane_d = tx_lane_q + 1'b1;
        end
    end

    // pack state and output holding registers
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            tx_acc_q  <= '0;
            tx_lane_q <= '0;
            tx_pend_q <= 1'b0;
            tx_data_q <= '0;
            tx_keep_q <= '0;
            tx_last_q <= 1'b0;
        end else begin
            tx_acc_q  <= tx_acc_d;
            tx_lane_q <= tx_lane_d;
            tx_pend_q <= tx_pend_d;
            tx_data_q <= tx_data_d;
            tx_keep_q <= tx_keep_d;
            tx_last_q <= tx_last_d;
        end
    end
endmodule

// File: tb/tb_pcileech_pcie_tlp_width_bridge.sv
// tb/tb_pcileech_pcie_tlp_width_bridge.sv - queue model plus directed vectors for the TLP width bridge
module tb_pcileech_pcie_tlp_width_bridge;
    logic user_clk;
    logic user_reset;

    pcileech_pcie_tlp_width_bridge_if #(.DATA_W(64)) b64 ();
    pcileech_pcie_tlp_width_bridge_if #(.DATA_W(32)) b32 ();

    pcileech_pcie_tlp_width_bridge #(.DATA_W(64)) dut64 (
        .user_clk   (user_clk),
        .user_reset (user_reset),
        .bus        (b64)
    );

    pcileech_pcie_tlp_width_bridge #(.DATA_W(32)) dut32 (
        .user_clk   (user_clk),
        .user_reset (user_reset),
        .bus        (b32)
    );

    initial begin
        user_clk = 1'b0;
        forever #5 user_clk = ~user_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    int n_cmp = 0;
    int n_bad = 0;
    int m_cmp = 0;
    int m_bad = 0;

    logic [33:0] exp_dw_q[$];
    beat_t       exp_beat_q[$];
    logic [31:0] part_q[$];
    logic [33:0] obs_dws[$];
    beat_t       obs_beats[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mchk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        m_cmp++;
        if (act !== exp) begin
            m_bad++;
            $display("FAIL model %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model for the 64-bit instance: every cycle, check outputs against expected queues,
    // then apply the handshakes that will complete on the coming rising edge.
    always @(negedge user_clk) begin
        beat_t bt;
        int    n;
        if (user_reset) begin
            mchk("rst_tlp_tx_valid", b64.tlp_tx_valid, 0);
            mchk("rst_tlp_tx_data", b64.tlp_tx_data, 0);
            mchk("rst_m_rx_tready", b64.m_axis_rx_tready, 0);
            mchk("rst_tlp_rx_ready", b64.tlp_rx_ready, 0);
            mchk("rst_s_tx_tvalid", b64.s_axis_tx_tvalid, 0);
            mchk("rst_s_tx_tdata", b64.s_axis_tx_tdata, 0);
            mchk("rst_s_tx_tkeep", b64.s_axis_tx_tkeep, 0);
            mchk("rst_s_tx_tlast", b64.s_axis_tx_tlast, 0);
            exp_dw_q.delete();
            exp_beat_q.delete();
            part_q.delete();
        end else begin
            mchk("m_rx_tready", b64.m_axis_rx_tready,
                 (exp_dw_q.size() == 0) || (b64.tlp_tx_ready && exp_dw_q.size() == 1));
            mchk("tlp_tx_valid", b64.tlp_tx_valid, exp_dw_q.size() != 0);
            if (exp_dw_q.size() != 0) mchk("tlp_tx_data", b64.tlp_tx_data, exp_dw_q[0]);
            mchk("tlp_rx_ready", b64.tlp_rx_ready, (exp_beat_q.size() == 0) || b64.s_axis_tx_tready);
            mchk("s_tx_tvalid", b64.s_axis_tx_tvalid, exp_beat_q.size() != 0);
            if (exp_beat_q.size() != 0) begin
                mchk("s_tx_tdata", b64.s_axis_tx_tdata, exp_beat_q[0].d);
                mchk("s_tx_tkeep", b64.s_axis_tx_tkeep, exp_beat_q[0].k);
                mchk("s_tx_tlast", b64.s_axis_tx_tlast, exp_beat_q[0].l);
            end

            if (b64.tlp_tx_valid && b64.tlp_tx_ready) begin
                obs_dws.push_back(b64.tlp_tx_data);
                if (exp_dw_q.size() != 0) void'(exp_dw_q.pop_front());
            end
            if (b64.m_axis_rx_tvalid && b64.m_axis_rx_tready) begin
                n = 0;
                for (int i = 0; i < 2; i++)
                    if (b64.m_axis_rx_tkeep[i*4 +: 4] == 4'hF) n = i + 1;
                for (int i = 0; i < n; i++)
                    exp_dw_q.push_back({b64.cfg_command_bus_master_enable,
                                        b64.m_axis_rx_tlast && (i == n - 1),
                                        b64.m_axis_rx_tdata[i*32 +: 32]});
            end

            if (b64.s_axis_tx_tvalid && b64.s_axis_tx_tready) begin
                obs_beats.push_back({b64.s_axis_tx_tdata, b64.s_axis_tx_tkeep, b64.s_axis_tx_tlast});
                if (exp_beat_q.size() != 0) void'(exp_beat_q.pop_front());
            end
            if (b64.tlp_rx_valid && b64.tlp_rx_ready) begin
                part_q.push_back(b64.tlp_rx_data[31:0]);
                if (b64.tlp_rx_data[32] || part_q.size() == 2) begin
                    bt = '0;
                    for (int i = 0; i < part_q.size(); i++) begin
                        bt.d[i*32 +: 32] = part_q[i];
                        bt.k[i*4 +: 4]   = 4'hF;
                    end
                    bt.l = b64.tlp_rx_data[32];
                    exp_beat_q.push_back(bt);
                    part_q.delete();
                end
            end
        end
    end

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic rx_send(input logic [63:0] d, input logic [7:0] k, input logic l, input logic bme);
        bit ok;
        ok = 1'b0;
        b64.m_axis_rx_tdata  = d;
        b64.m_axis_rx_tkeep  = k;
        b64.m_axis_rx_tlast  = l;
        b64.cfg_command_bus_master_enable = bme;
        b64.m_axis_rx_tvalid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge user_clk);
            ok = b64.m_axis_rx_tready;
            step();
        end
        b64.m_axis_rx_tvalid = 1'b0;
        chk("rx_send_accepted", ok, 1);
    endtask

    task automatic fifo_send(input logic [31:0] dw, input logic last);
        bit ok;
        ok = 1'b0;
        b64.tlp_rx_data  = {1'b0, last, dw};
        b64.tlp_rx_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge user_clk);
            ok = b64.tlp_rx_ready;
            step();
        end
        b64.tlp_rx_valid = 1'b0;
        chk("fifo_send_accepted", ok, 1);
    endtask

    localparam logic [63:0] TBL_D [4] = '{64'hA2A2A2A2_A1A1A1A1, 64'hFFFFFFFF_B1B1B1B1,
                                          64'hC2C2C2C2_C1C1C1C1, 64'h99999999_D1D1D1D1};
    localparam logic [7:0]  TBL_K [4] = '{8'hFF, 8'h0F, 8'hFF, 8'h0F};
    localparam logic        TBL_L [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int n0;
        logic [7:0] pat;
        b64.m_axis_rx_tdata = '0; b64.m_axis_rx_tkeep = '0; b64.m_axis_rx_tlast = 0; b64.m_axis_rx_tvalid = 0;
        b64.cfg_command_bus_master_enable = 0;
        b64.tlp_tx_ready = 1; b64.tlp_rx_data = '0; b64.tlp_rx_valid = 0; b64.s_axis_tx_tready = 1;
        b32.m_axis_rx_tdata = '0; b32.m_axis_rx_tkeep = '0; b32.m_axis_rx_tlast = 0; b32.m_axis_rx_tvalid = 0;
        b32.cfg_command_bus_master_enable = 0;
        b32.tlp_tx_ready = 1; b32.tlp_rx_data = '0; b32.tlp_rx_valid = 0; b32.s_axis_tx_tready = 1;
        user_reset = 1'b1;

        // reset state and first cycle after release
        repeat (3) step();
        @(negedge user_clk);
        chk("reset_tlp_tx_valid", b64.tlp_tx_valid, 0);
        chk("reset_m_rx_tready", b64.m_axis_rx_tready, 0);
        chk("reset_tlp_rx_ready", b64.tlp_rx_ready, 0);
        chk("reset32_m_rx_tready", b32.m_axis_rx_tready, 0);
        step();
        user_reset = 1'b0;
        @(negedge user_clk);
        chk("post_reset_m_rx_tready", b64.m_axis_rx_tready, 1);
        chk("post_reset_tlp_rx_ready", b64.tlp_rx_ready, 1);
        chk("post_reset32_m_rx_tready", b32.m_axis_rx_tready, 1);
        step();

        // two-DW beat with tlast and BME set
        b64.m_axis_rx_tdata = 64'h22222222_11111111; b64.m_axis_rx_tkeep = 8'hFF;
        b64.m_axis_rx_tlast = 1; b64.cfg_command_bus_master_enable = 1; b64.m_axis_rx_tvalid = 1;
        @(negedge user_clk);
        chk("v031_tready", b64.m_axis_rx_tready, 1);
        step();
        b64.m_axis_rx_tvalid = 0;
        @(negedge user_clk);
        chk("v031_dw0_valid", b64.tlp_tx_valid, 1);
        chk("v031_dw0", b64.tlp_tx_data, 34'h2_11111111);
        step();
        @(negedge user_clk);
        chk("v031_dw1", b64.tlp_tx_data, 34'h3_22222222);
        step();
        @(negedge user_clk);
        chk("v031_idle", b64.tlp_tx_valid, 0);
        step();

        // single-lane beat, upper lane masked off by tkeep
        b64.m_axis_rx_tdata = 64'h55555555_DEADBEEF; b64.m_axis_rx_tkeep = 8'h0F;
        b64.m_axis_rx_tlast = 1; b64.cfg_command_bus_master_enable = 0; b64.m_axis_rx_tvalid = 1;
        step();
        b64.m_axis_rx_tvalid = 0;
        @(negedge user_clk);
        chk("v032_dw0", b64.tlp_tx_data, 34'h1_DEADBEEF);
        step();
        @(negedge user_clk);
        chk("v032_no_second_dw", b64.tlp_tx_valid, 0);
        step();

        // FIFO stall in the middle of a beat, next beat waiting
        n0 = obs_dws.size();
        b64.m_axis_rx_tdata = 64'h33333333_44444444; b64.m_axis_rx_tkeep = 8'hFF;
        b64.m_axis_rx_tlast = 0; b64.cfg_command_bus_master_enable = 1; b64.m_axis_rx_tvalid = 1;
        step();
        b64.m_axis_rx_tdata = 64'h66666666_55555555; b64.m_axis_rx_tlast = 1;
        step();
        b64.tlp_tx_ready = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge user_clk);
            chk("v034_stall_data", b64.tlp_tx_data, 34'h2_33333333);
            chk("v034_stall_tready", b64.m_axis_rx_tready, 0);
            step();
        end
        b64.tlp_tx_ready = 1;
        @(negedge user_clk);
        chk("v034_release_tready", b64.m_axis_rx_tready, 1);
        step();
        b64.m_axis_rx_tvalid = 0;
        repeat (4) step();
        chk("v034_dw_count", obs_dws.size() - n0, 4);
        chk("v034_dw1", obs_dws[n0+1], 34'h2_33333333);
        chk("v034_dw2", obs_dws[n0+2], 34'h2_55555555);
        chk("v034_dw3", obs_dws[n0+3], 34'h3_66666666);

        // table of beats with the FIFO ready toggling
        n0 = obs_dws.size();
        pat = 8'b1011_0110;
        fork
            for (int i = 0; i < 4; i++) rx_send(TBL_D[i], TBL_K[i], TBL_L[i], i[0]);
            for (int c = 0; c < 40; c++) begin
                b64.tlp_tx_ready = pat[c % 8];
                step();
            end
        join
        b64.tlp_tx_ready = 1;
        repeat (4) step();
        chk("table_dw_count", obs_dws.size() - n0, 6);
        chk("table_dw_b1", obs_dws[n0+2], 34'h3_B1B1B1B1);

        // three FIFO DWs -> one full beat and one partial closing beat
        n0 = obs_beats.size();
        fifo_send(32'hAAAAAAAA, 0);
        fifo_send(32'hBBBBBBBB, 0);
        fifo_send(32'hCCCCCCCC, 1);
        repeat (3) step();
        chk("v033_beats", obs_beats.size() - n0, 2);
        chk("v033_b0_data", obs_beats[n0].d, 64'hBBBBBBBB_AAAAAAAA);
        chk("v033_b0_keep", obs_beats[n0].k, 8'hFF);
        chk("v033_b0_last", obs_beats[n0].l, 0);
        chk("v033_b1_data", obs_beats[n0+1].d, 64'h00000000_CCCCCCCC);
        chk("v033_b1_keep", obs_beats[n0+1].k, 8'h0F);
        chk("v033_b1_last", obs_beats[n0+1].l, 1);

        // core backpressure while the FIFO keeps offering DWs
        n0 = obs_beats.size();
        b64.s_axis_tx_tready = 0;
        fork
            begin
                fifo_send(32'h10000001, 0);
                fifo_send(32'h10000002, 0);
                fifo_send(32'h10000003, 0);
                fifo_send(32'h10000004, 1);
            end
            begin
                repeat (6) step();
                b64.s_axis_tx_tready = 1;
            end
        join
        repeat (3) step();
        chk("bp_beats", obs_beats.size() - n0, 2);
        chk("bp_b0_data", obs_beats[n0].d, 64'h10000002_10000001);
        chk("bp_b1_data", obs_beats[n0+1].d, 64'h10000004_10000003);
        chk("bp_b1_last", obs_beats[n0+1].l, 1);

        // reset with a partial TX beat: nothing emitted, next beat restarts at lane 0
        n0 = obs_beats.size();
        fifo_send(32'h11111111, 0);
        user_reset = 1;
        step();
        user_reset = 0;
        fifo_send(32'h12345678, 1);
        repeat (3) step();
        chk("v035_beats", obs_beats.size() - n0, 1);
        chk("v035_data", obs_beats[n0].d, 64'h00000000_12345678);
        chk("v035_keep", obs_beats[n0].k, 8'h0F);
        chk("v035_last", obs_beats[n0].l, 1);

        // reset with a captured RX beat: it is dropped
        n0 = obs_dws.size();
        b64.tlp_tx_ready = 0;
        rx_send(64'h77777777_88888888, 8'hFF, 1, 1);
        user_reset = 1;
        step();
        user_reset = 0;
        b64.tlp_tx_ready = 1;
        @(negedge user_clk);
        chk("rx_reset_valid", b64.tlp_tx_valid, 0);
        chk("rx_reset_tready", b64.m_axis_rx_tready, 1);
        step();
        repeat (2) step();
        chk("rx_reset_dw_count", obs_dws.size() - n0, 0);

        // 32-bit instance: 16 back-to-back beats at one DW per cycle
        b32.cfg_command_bus_master_enable = 1;
        b32.m_axis_rx_tdata = 32'hB0000000; b32.m_axis_rx_tkeep = 4'hF;
        b32.m_axis_rx_tlast = 0; b32.m_axis_rx_tvalid = 1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge user_clk);
            if (k < 16) chk("v036_tready", b32.m_axis_rx_tready, 1);
            if (k >= 1) begin
                chk("v036_valid", b32.tlp_tx_valid, 1);
                chk("v036_dw", b32.tlp_tx_data, {1'b1, 1'(k == 16), 32'(32'hB0000000 + k - 1)});
            end
            step();
            if (k < 15) begin
                b32.m_axis_rx_tdata = 32'(32'hB0000000 + k + 1);
                b32.m_axis_rx_tlast = (k + 1 == 15);
            end else begin
                b32.m_axis_rx_tvalid = 0;
            end
        end
        @(negedge user_clk);
        chk("v036_idle", b32.tlp_tx_valid, 0);
        step();

        // 32-bit instance: one DW fills the beat; bit 33 is ignored
        b32.tlp_rx_data = {1'b1, 1'b0, 32'hCAFEF00D};
        b32.tlp_rx_valid = 1;
        @(negedge user_clk);
        chk("pack32_ready", b32.tlp_rx_ready, 1);
        step();
        b32.tlp_rx_valid = 0;
        @(negedge user_clk);
        chk("pack32_valid", b32.s_axis_tx_tvalid, 1);
        chk("pack32_data", b32.s_axis_tx_tdata, 32'hCAFEF00D);
        chk("pack32_keep", b32.s_axis_tx_tkeep, 4'hF);
        chk("pack32_last", b32.s_axis_tx_tlast, 0);
        step();
        @(negedge user_clk);
        chk("pack32_idle", b32.s_axis_tx_tvalid, 0);
        step();

        n_cmp += m_cmp;
        n_bad += m_bad;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pcileech_pcie_tlp_width_bridge.md
PCILEECH_PCIE_TLP_WIDTH_BRIDGE -- requirements
Module: pcileech_pcie_tlp_width_bridge

Interface
REQ-001 Parameter DATA_W, default 64, meaning the PCIe core AXI-stream data width; legal values are 32, 64 and 128, and any other value SHALL cause an elaboration error.
REQ-002 Parameter KEEP_W, default DATA_W/8, meaning the tkeep width; it SHALL be derived from DATA_W and SHALL NOT be overridden.
REQ-003 user_clk  in  1  is the single clock; every register SHALL be clocked on its rising edge.
REQ-004 user_reset  in  1  is the reset; it SHALL be synchronous and active-high.
REQ-005 m_axis_rx_tdata/tkeep/tlast/tvalid  in  DATA_W/KEEP_W/1/1  carry RX TLP beats from the core.
REQ-006 m_axis_rx_tready  out  1  is the RX backpressure output to the core.
REQ-007 cfg_command_bus_master_enable  in  1  is the BME bit of the command register.
REQ-008 tlp_tx_data  out  34  carries TLP DWs to the FIFO: [31:0] DW, [32] last, [33] BME.
REQ-009 tlp_tx_valid out 1 and tlp_tx_ready in 1 form the FIFO-side output handshake.
REQ-010 tlp_rx_data  in  34  carries TLP DWs from the FIFO: [31:0] DW, [32] last, [33] ignored.
REQ-011 tlp_rx_valid in 1 and tlp_rx_ready out 1 form the FIFO-side input handshake.
REQ-012 s_axis_tx_tdata/tkeep/tlast/tvalid  out  DATA_W/KEEP_W/1/1  carry TX beats to the core.
REQ-013 s_axis_tx_tready  in  1  is the core TX backpressure input.

Function -- RX unpack (core to FIFO)
REQ-014 A beat SHALL transfer when m_axis_rx_tvalid and m_axis_rx_tready are both 1; it is then held in an unpack register.
REQ-015 The unpack register SHALL emit its DWs lowest lane first, one DW per cycle in which tlp_tx_ready=1.
REQ-016 Only lanes whose 4-bit tkeep group is 4'hF SHALL be emitted; valid lanes are contiguous from lane 0.
REQ-017 tlp_tx_data[32] SHALL be 1 only on the last valid DW of a beat that had tlast=1.
REQ-018 tlp_tx_data[33] SHALL equal cfg_command_bus_master_enable as registered when the beat is captured.
REQ-019 The first DW of a beat SHALL be valid exactly 1 cycle after that beat's acceptance.
REQ-020 m_axis_rx_tready SHALL equal (register empty) OR (tlp_tx_ready AND the final valid DW is being presented), so that DATA_W=32 sustains 1 DW per cycle.
REQ-021 While tlp_tx_valid=1 and tlp_tx_ready=0, tlp_tx_data SHALL remain stable.

Function -- TX pack (FIFO to core)
REQ-022 A DW SHALL transfer when tlp_rx_valid and tlp_rx_ready are both 1; it is written to the next lane, starting at lane 0.
REQ-023 A beat SHALL close when DATA_W/32 lanes are filled or when a DW with bit 32 set is accepted.
REQ-024 On close, tkeep SHALL be 4'hF for each filled lane and 0 otherwise; unfilled lanes SHALL carry data 0; tlast SHALL equal bit 32 of the closing DW.
REQ-025 s_axis_tx_tvalid SHALL assert the cycle after the closing DW is accepted, and outputs SHALL hold until s_axis_tx_tready=1.
REQ-026 tlp_rx_ready SHALL equal NOT(beat pending) OR s_axis_tx_tready.
REQ-027 After a closing DW, the lane index SHALL wrap to 0.

Reset
REQ-028 While user_reset=1: tlp_tx_valid=0, s_axis_tx_tvalid=0, m_axis_rx_tready=0, tlp_rx_ready=0, tlp_tx_data=0, s_axis_tx_tdata/tkeep/tlast=0, lane index=0.
REQ-029 Reset asserted mid-packet SHALL discard all partial and pending DWs and beats; the next packet SHALL start at lane 0.
REQ-030 In the first cycle after user_reset deasserts, m_axis_rx_tready and tlp_rx_ready SHALL be 1.

Verification
REQ-031 DATA_W=64, beat 64'h22222222_11111111, keep 8'hFF, tlast=1, BME=1, tlp_tx_ready=1 -> output 34'h2_11111111 at acceptance+1, then 34'h3_22222222 at acceptance+2.
REQ-032 DATA_W=64, keep 8'h0F, tlast=1, DW 32'hDEADBEEF, BME=0 -> a single output 34'h1_DEADBEEF and no second DW.
REQ-033 DATA_W=64, FIFO DWs AAAAAAAA, BBBBBBBB, then CCCCCCCC with bit32=1 -> beat BBBBBBBB_AAAAAAAA/keep FF/tlast 0, then beat 00000000_CCCCCCCC/keep 0F/tlast 1.
REQ-034 tlp_tx_ready held 0 for 5 cycles mid-beat -> tlp_tx_data stable, m_axis_rx_tready=0, no DW lost or duplicated after release.
REQ-035 One DW accepted, then user_reset pulsed for 1 cycle -> no TX beat is emitted, and the next DW 32'h12345678 with bit32=1 yields a beat with keep 8'h0F.
REQ-036 DATA_W=32, 16 back-to-back RX beats, tlp_tx_ready=1 -> 16 outputs on 16 consecutive cycles with m_axis_rx_tready constantly 1.
